// File: rtl/fpu_arbiter_if.sv
// Requester and response handshake bundle between two FPU clients, the
// arbiter and the result consumer.
interface fpu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_status;

   modport slave (
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_data, rsp_status
   );

   modport master (
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_data, rsp_status
   );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FPU between two requesters,
// one operation in flight, result held until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a request; grant computed combinationally
// LOAD  | one cycle with the FPU held in reset on the new operands
// RUN   | down-counting the FPU latency, capture on terminal count
// RESP  | result held on the response port until taken
module fpu_arbiter #(
   parameter int unsigned WAIT_CYCLES = 40
) (
   input  logic          clock100KHz,
   input  logic          reset,
   fpu_arbiter_if.slave  bus,
   output logic [31:0]   fpu_op_a,
   output logic [31:0]   fpu_op_b,
   output logic          fpu_reset,
   input  logic [31:0]   fpu_data,
   input  logic [3:0]    fpu_status,
   output logic          busy,
   output logic [7:0]    ovf_count
);

   localparam logic [7:0] CNT_LOAD = 8'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

   state_t      state;
   logic        last_grant;
   logic [7:0]  counter;
   logic        rsp_valid;
   logic        rsp_id;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_status;
   logic        grant0;
   logic        grant1;

   // Reset gating keeps both readies low while the block is held in reset.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (reset && state == IDLE) begin
         if (bus.req0_valid && (!bus.req1_valid || last_grant))
            grant0 = 1'b1;
         else if (bus.req1_valid)
            grant1 = 1'b1;
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.rsp_valid  = rsp_valid;
   assign bus.rsp_id     = rsp_id;
   assign bus.rsp_data   = rsp_data;
   assign bus.rsp_status = rsp_status;
   assign busy           = (state != IDLE);

   always_ff @(posedge clock100KHz or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         counter    <= 8'd0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= 32'd0;
         rsp_status <= 4'd0;
         fpu_op_a   <= 32'd0;
         fpu_op_b   <= 32'd0;
         fpu_reset  <= 1'b0;
         ovf_count  <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               fpu_reset <= 1'b1;
               if (grant0 || grant1) begin
                  fpu_op_a   <= grant1 ? bus.req1_a : bus.req0_a;
                  fpu_op_b   <= grant1 ? bus.req1_b : bus.req0_b;
                  rsp_id     <= grant1;
                  last_grant <= grant1;
                  fpu_reset  <= 1'b0;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               fpu_reset <= 1'b1;
               counter   <= CNT_LOAD;
               state     <= RUN;
            end
            RUN: begin
               if (counter == 8'd0) begin
                  rsp_data   <= fpu_data;
                  rsp_status <= fpu_status;
                  rsp_valid  <= 1'b1;
                  if (fpu_status[2] && ovf_count != 8'hFF)
                     ovf_count <= ovf_count + 8'd1;
                  state      <= RESP;
               end else begin
                  counter <= counter - 8'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: arbitration table, scoreboarded responses, back-pressure,
// mid-run reset, overflow saturation and a short-latency instance.
module tb_fpu_arbiter;

   localparam int unsigned LAT = 41;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fpu_arbiter_if ifm ();
   fpu_arbiter_if ifs ();

   logic [31:0] op_a, op_b, fd, op_a34, op_b34, fd34;
   logic [3:0]  fs, fs34;
   logic        fr, fr34, busy, busy34;
   logic [7:0]  ovf, ovf34;
   logic        force_ovf;

   function automatic logic [31:0] fm_data(input logic [31:0] a, input logic [31:0] b);
      return (a ^ {b[15:0], b[31:16]}) + 32'h0000_1234;
   endfunction

   function automatic logic [3:0] fm_status(input logic [31:0] a, input logic [31:0] b,
                                            input logic frc);
      logic [8:0] es;
      es = {1'b0, a[30:23]} + {1'b0, b[30:23]};
      if (frc) return 4'b0100;
      return {1'b0, (es > 9'd381), 1'b0, (a == 32'd0)};
   endfunction

   assign fd   = fm_data(op_a, op_b);
   assign fs   = fm_status(op_a, op_b, force_ovf);
   assign fd34 = fm_data(op_a34, op_b34);
   assign fs34 = fm_status(op_a34, op_b34, 1'b0);

   fpu_arbiter #(.WAIT_CYCLES(40)) dut (
      .clock100KHz(clk), .reset(reset), .bus(ifm),
      .fpu_op_a(op_a), .fpu_op_b(op_b), .fpu_reset(fr),
      .fpu_data(fd), .fpu_status(fs), .busy(busy), .ovf_count(ovf)
   );

   fpu_arbiter #(.WAIT_CYCLES(34)) dut34 (
      .clock100KHz(clk), .reset(reset), .bus(ifs),
      .fpu_op_a(op_a34), .fpu_op_b(op_b34), .fpu_reset(fr34),
      .fpu_data(fd34), .fpu_status(fs34), .busy(busy34), .ovf_count(ovf34)
   );

   typedef struct packed {
      logic        id;
      logic [31:0] data;
      logic [3:0]  status;
   } exp_t;

   typedef struct {
      bit          v0;
      bit          v1;
      logic [31:0] a0, b0, a1, b1;
      bit          exp_id;
   } vec_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          id_log[$];
   int unsigned cyc = 0;
   int unsigned acc_cyc = 0;
   int unsigned n_acc = 0;
   int          checks = 0;
   int          errors = 0;
   int          ovf_exp = 0;

   // Scoreboard: expected result is pushed on every acceptance edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         if (ifm.req0_valid && ifm.req0_ready) begin
            mon_e.id     = 1'b0;
            mon_e.data   = fm_data(ifm.req0_a, ifm.req0_b);
            mon_e.status = fm_status(ifm.req0_a, ifm.req0_b, force_ovf);
            exp_q.push_back(mon_e);
            id_log.push_back(0);
            acc_cyc <= cyc;
            n_acc   <= n_acc + 1;
         end else if (ifm.req1_valid && ifm.req1_ready) begin
            mon_e.id     = 1'b1;
            mon_e.data   = fm_data(ifm.req1_a, ifm.req1_b);
            mon_e.status = fm_status(ifm.req1_a, ifm.req1_b, force_ovf);
            exp_q.push_back(mon_e);
            id_log.push_back(1);
            acc_cyc <= cyc;
            n_acc   <= n_acc + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_accept();
      int unsigned start;
      int n;
      start = n_acc;
      n = 0;
      while (n_acc == start && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("accept_seen", (n_acc != start), 1);
      chk("fpu_reset_load", fr, 0);
      chk("busy_load", busy, 1);
      @(negedge clk);
      chk("fpu_reset_run", fr, 1);
      chk("ready_closed", {ifm.req1_ready, ifm.req0_ready}, 0);
   endtask

   task automatic wait_rsp();
      int   n;
      exp_t e;
      n = 0;
      while (!ifm.rsp_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_seen", ifm.rsp_valid, 1);
      if (ifm.rsp_valid) begin
         chk("latency", cyc - acc_cyc - 1, LAT);
         if (exp_q.size() == 0) begin
            chk("sb_nonempty", 0, 1);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_id", ifm.rsp_id, e.id);
            chk("rsp_data", ifm.rsp_data, e.data);
            chk("rsp_status", ifm.rsp_status, e.status);
            if (e.status[2] && ovf_exp < 255) ovf_exp++;
            chk("ovf_count", ovf, ovf_exp);
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      ifm.req0_valid = v.v0; ifm.req0_a = v.a0; ifm.req0_b = v.b0;
      ifm.req1_valid = v.v1; ifm.req1_a = v.a1; ifm.req1_b = v.b1;
      #1;
      chk("ready_pre", {ifm.req1_ready, ifm.req0_ready}, v.exp_id ? 2 : 1);
      wait_accept();
      if (id_log.size() > 0) chk("grant", id_log[$], v.exp_id);
      ifm.req0_valid = 1'b0;
      ifm.req1_valid = 1'b0;
      wait_rsp();
      @(negedge clk);
      chk("rsp_released", ifm.rsp_valid, 0);
      chk("idle_after", busy, 0);
   endtask

   vec_t        tbl[10];
   vec_t        v;
   int unsigned t_acc[4];
   int          base;
   int          n;
   bit          ok;
   logic [31:0] saved;

   initial begin
      tbl[0] = '{1, 0, 32'h4000_0000, 32'h4000_0000, 32'h0, 32'h0, 0};
      tbl[1] = '{0, 1, 32'h0, 32'h0, 32'h3F80_0000, 32'h4040_0000, 1};
      tbl[2] = '{1, 1, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_0000, 0};
      tbl[3] = '{1, 1, 32'hA0A0_0001, 32'h0B0B_0002, 32'hC0C0_0003, 32'h0D0D_0004, 1};
      tbl[4] = '{1, 1, 32'h7E00_0000, 32'h7E00_0000, 32'h0000_0001, 32'h0000_0002, 0};
      tbl[5] = '{1, 1, 32'h0000_0000, 32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1};
      tbl[6] = '{0, 1, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000, 32'h4000_0000, 1};
      tbl[7] = '{1, 1, 32'h3F00_0000, 32'h3E00_0000, 32'h4100_0000, 32'h4200_0000, 0};
      tbl[8] = '{1, 0, 32'h8000_0001, 32'h0101_0101, 32'h0, 32'h0, 0};
      tbl[9] = '{1, 1, 32'h2222_2222, 32'h4444_4444, 32'h7F00_0000, 32'h7F00_0000, 1};

      reset = 1'b0;
      force_ovf = 1'b0;
      ifm.req0_valid = 1'b1; ifm.req0_a = 32'h1; ifm.req0_b = 32'h2;
      ifm.req1_valid = 1'b1; ifm.req1_a = 32'h3; ifm.req1_b = 32'h4;
      ifm.rsp_ready = 1'b0;
      ifs.req0_valid = 1'b0; ifs.req0_a = 32'h0; ifs.req0_b = 32'h0;
      ifs.req1_valid = 1'b0; ifs.req1_a = 32'h0; ifs.req1_b = 32'h0;
      ifs.rsp_ready = 1'b1;
      #12;
      chk("rst_ready", {ifm.req1_ready, ifm.req0_ready}, 0);
      chk("rst_fpu_reset", fr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", ifm.rsp_valid, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_op_a", op_a, 0);
      @(negedge clk);
      ifm.req0_valid = 1'b0;
      ifm.req1_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("fpu_reset_release", fr, 1);
      chk("busy_release", busy, 0);
      ifm.rsp_ready = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(tbl[i]);

      // Both requesters held continuously: strict alternation at minimum spacing.
      @(negedge clk);
      ifm.req0_valid = 1'b1; ifm.req0_a = 32'h4000_0000; ifm.req0_b = 32'h3F80_0000;
      ifm.req1_valid = 1'b1; ifm.req1_a = 32'h4080_0000; ifm.req1_b = 32'h40A0_0000;
      base = id_log.size();
      for (int i = 0; i < 4; i++) begin
         wait_accept();
         t_acc[i] = acc_cyc;
         wait_rsp();
      end
      ifm.req0_valid = 1'b0;
      ifm.req1_valid = 1'b0;
      @(negedge clk);
      chk("rr_released", ifm.rsp_valid, 0);
      chk("rr_count", id_log.size() - base, 4);
      for (int i = 0; i < 4; i++)
         if (id_log.size() > base + i) chk("rr_order", id_log[base + i], i % 2);
      for (int i = 1; i < 4; i++) chk("rr_spacing", t_acc[i] - t_acc[i-1], LAT + 2);

      // Consumer back-pressure for 20 cycles with both requesters waiting.
      ifm.rsp_ready = 1'b0;
      @(negedge clk);
      ifm.req0_valid = 1'b1; ifm.req0_a = 32'h4110_0000; ifm.req0_b = 32'h4120_0000;
      base = id_log.size();
      wait_accept();
      ifm.req1_valid = 1'b1;
      wait_rsp();
      saved = ifm.rsp_data;
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!ifm.rsp_valid || ifm.rsp_data !== saved || ifm.req0_ready || ifm.req1_ready)
            ok = 1'b0;
      end
      chk("hold_stable", ok, 1);
      ifm.req0_valid = 1'b0;
      ifm.req1_valid = 1'b0;
      ifm.rsp_ready = 1'b1;
      @(negedge clk);
      chk("hold_released", ifm.rsp_valid, 0);
      chk("hold_idle", busy, 0);
      chk("hold_single_accept", id_log.size() - base, 1);

      // Reset while RUN counter is 10; the in-flight result must vanish.
      @(negedge clk);
      ifm.req1_valid = 1'b1; ifm.req1_a = 32'hABCD_0123; ifm.req1_b = 32'h4567_89AB;
      wait_accept();
      ifm.req1_valid = 1'b0;
      n = 0;
      while (cyc != acc_cyc + 31 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reset_point", cyc - acc_cyc, 31);
      ifm.req0_valid = 1'b1;
      ifm.req1_valid = 1'b1;
      reset = 1'b0;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_rsp_valid", ifm.rsp_valid, 0);
      chk("mid_rsp_id", ifm.rsp_id, 0);
      chk("mid_rsp_data", ifm.rsp_data, 0);
      chk("mid_rsp_status", ifm.rsp_status, 0);
      chk("mid_op_a", op_a, 0);
      chk("mid_op_b", op_b, 0);
      chk("mid_fpu_reset", fr, 0);
      chk("mid_ovf", ovf, 0);
      chk("mid_ready", {ifm.req1_ready, ifm.req0_ready}, 0);
      @(negedge clk);
      chk("mid_ready_held", {ifm.req1_ready, ifm.req0_ready}, 0);
      ifm.req0_valid = 1'b0;
      ifm.req1_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      ovf_exp = 0;
      @(negedge clk);
      chk("mid_fpu_reset_release", fr, 1);
      ok = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ifm.rsp_valid) ok = 1'b0;
      end
      chk("mid_no_rsp", ok, 1);
      v = '{1, 1, 32'h4000_0000, 32'h3F00_0000, 32'h4200_0000, 32'h4300_0000, 0};
      run_vec(v);

      // Overflow counter saturation.
      force_ovf = 1'b1;
      for (int i = 0; i < 300; i++) begin
         v = '{1, 0, 32'h1000_0000 + i, 32'h2000_0000 ^ i, 32'h0, 32'h0, 0};
         run_vec(v);
      end
      chk("ovf_saturated", ovf, 255);
      force_ovf = 1'b0;

      // Shortest legal latency instance.
      @(negedge clk);
      ifs.req0_valid = 1'b1; ifs.req0_a = 32'h7E00_0000; ifs.req0_b = 32'h7E00_0000;
      #1;
      chk("s_ready", ifs.req0_ready, 1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) ifs.req0_valid = 1'b0;
      end while (!ifs.rsp_valid && n < 100);
      chk("s_latency", n - 1, 35);
      chk("s_id", ifs.rsp_id, 0);
      chk("s_data", ifs.rsp_data, fm_data(32'h7E00_0000, 32'h7E00_0000));
      chk("s_status_ovf", ifs.rsp_status[2], 1);
      chk("s_ovf_count", ovf34, 1);
      @(negedge clk);
      chk("s_released", ifs.rsp_valid, 0);
      chk("s_idle", busy34, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
